s2p_deserializer: RTL and testbench
===================================

// Module: s2p_deserializer
// PURPOSE
//   Serial-to-parallel converter for the chat link receive path.
//   - Samples one bit of dataIn on every rising edge of srClock.
//   - Shifts each bit into a WIDTH-bit register and presents that register continuously on data.
//   - Downstream logic reads data once a full character has been shifted in.
// PARAMETERS
//   WIDTH      8   parallel word width in bits (>= 2)
//   MSB_FIRST  1   1: new bit enters data[0] and older bits move toward data[WIDTH-1]
//                  0: new bit enters data[WIDTH-1] and older bits move toward data[0]
// PORTS
//   srClock      in   1      shift clock; all state updates on its rising edge
//   rst          in   1      reset; synchronous, active-high
//   dataIn       in   1      serial data bit, sampled at rising srClock
//   data         out  WIDTH  parallel shift-register contents (registered)
//   frame_valid  out  1      only when S2P_FRAME_EN is defined; see CONFIGURATION
//   frame_data   out  WIDTH  only when S2P_FRAME_EN is defined; see CONFIGURATION
// BEHAVIOUR
//   - One clock (srClock). Reset is synchronous and active-high.
//   - rst=1 at a rising edge: data <= 0. Reset has priority over shifting; dataIn is ignored that cycle.
//   - rst=0 at a rising edge:
//       MSB_FIRST=1: data <= {data[WIDTH-2:0], dataIn}
//       MSB_FIRST=0: data <= {dataIn, data[WIDTH-1:1]}
//   - Latency: a bit sampled at edge N is visible on data after edge N.
//     With MSB_FIRST=1 it reaches data[WIDTH-1] after WIDTH edges and is discarded on edge WIDTH+1.
//   - No enable input. The register shifts on every non-reset edge.
//   - Idle line level is the sender's responsibility: a constant dataIn fills data with that value.
//   - Reset mid-word: partial contents are discarded and data=0 on the next edge.
//   - data is a pure register output; there is no combinational path from dataIn to data.
// CONFIGURATION
//   Macro S2P_FRAME_EN.
//   Defined:
//     - Adds a bit counter, 0..WIDTH-1 with wrap, and the frame_valid/frame_data ports.
//     - Counter: cleared by rst; increments on every non-reset edge.
//     - On the edge where the counter wraps WIDTH-1 -> 0 (the WIDTH-th bit since reset or since the
//       last frame): frame_data <= the new data value and frame_valid <= 1.
//     - frame_valid stays high for exactly one cycle and is 0 on all other edges.
//     - rst clears the counter, frame_valid and frame_data.
//     - data behaves exactly as without the macro.
//   Undefined:
//     - Counter and both extra ports are absent.
//     - Only the free-running shift register exists.
// TESTING
//   Defaults WIDTH=8, MSB_FIRST=1.
//   1. Reset: rst=1 for one edge with any dataIn -> data=8'h00.
//   2. Word shift:
//      - after reset, drive 0,0,1,1,0,1,1,1 on 8 edges -> data=8'h37.
//      - continue with 0,1 -> data=8'h6E, then 8'hDD.
//   3. Saturation: hold dataIn=1 for 8 edges -> data=8'hFF; then hold 0 for 8 edges -> 8'h00.
//   4. Reset priority: rst=1 with dataIn=1 while data=8'hDD -> data=8'h00 on the next edge;
//      the first non-reset edge with dataIn=1 -> 8'h01.
//   5. Direction: MSB_FIRST=0, shift 1 then seven 0s after reset -> data=8'h01.
//   6. S2P_FRAME_EN:
//      - after reset, shift 0,0,1,1,0,1,1,1 -> frame_valid=1 for one cycle and frame_data=8'h37.
//      - the next 7 bits give no pulse; the 8th bit gives a pulse again.
//      - rst after 4 bits restarts the count, so no pulse occurs until 8 more bits.

Source files
------------

// File: rtl/s2p_deserializer.sv
// Serial-to-parallel shift register for the chat link receive path.
// Optional framing (bit counter, frame_valid/frame_data) enabled by defining S2P_FRAME_EN.
module s2p_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             srClock,
    input  logic             rst,
    input  logic             dataIn,
`ifdef S2P_FRAME_EN
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame_data,
`endif
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Shift direction selects which end the new bit enters from
    always_comb begin
        data_d = data_q;
        if (MSB_FIRST) begin
            data_d = {data_q[WIDTH-2:0], dataIn};
        end else begin
            data_d = {dataIn, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge srClock) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

`ifdef S2P_FRAME_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_c;
    logic             frame_valid_q;
    logic [WIDTH-1:0] frame_data_q;

    // Bit counter wraps after every WIDTH-th bit; that edge completes a frame
    always_comb begin
        wrap_c = (cnt_q == CNT_LAST);
        cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge srClock) begin
        if (rst) begin
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            frame_valid_q <= wrap_c;
            if (wrap_c) begin
                frame_data_q <= data_d;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
`endif

endmodule

// File: tb/tb_s2p_deserializer.sv
// Randomized self-checking bench for s2p_deserializer; checks both shift directions
// against a bit-history model, plus framing outputs when S2P_FRAME_EN is defined.
module tb_s2p_deserializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         din;
    logic [W-1:0] data_m;
    logic [W-1:0] data_l;
`ifdef S2P_FRAME_EN
    logic         fv_m;
    logic [W-1:0] fd_m;
    logic         fv_l;
    logic [W-1:0] fd_l;
`endif

    int checks = 0;
    int errors = 0;

    // Model: most recent bits since reset (index 0 newest), bit count since reset
    bit           hist[$];
    int unsigned  nbits;
    bit           exp_fv;
    logic [W-1:0] exp_fd_m;
    logic [W-1:0] exp_fd_l;

    s2p_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .srClock    (clk),
        .rst        (rst),
        .dataIn     (din),
`ifdef S2P_FRAME_EN
        .frame_valid(fv_m),
        .frame_data (fd_m),
`endif
        .data       (data_m)
    );

    s2p_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .srClock    (clk),
        .rst        (rst),
        .dataIn     (din),
`ifdef S2P_FRAME_EN
        .frame_valid(fv_l),
        .frame_data (fd_l),
`endif
        .data       (data_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word as seen by a given direction: bit i edges ago sits at index i (msb) or W-1-i (lsb)
    function automatic logic [W-1:0] exp_data(input bit msb);
        logic [W-1:0] r;
        bit           b;
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            b = (i < hist.size()) ? hist[i] : 1'b0;
            if (msb) r[i] = b;
            else     r[W-1-i] = b;
        end
        return r;
    endfunction

    // Drive one edge, then update the model; outputs are sampled 1 time unit later
    task automatic drive(input bit r, input bit d);
        rst = r;
        din = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
            nbits    = 0;
            exp_fv   = 1'b0;
            exp_fd_m = '0;
            exp_fd_l = '0;
        end else begin
            hist.push_front(d);
            if (hist.size() > W) void'(hist.pop_back());
            nbits++;
            exp_fv = (nbits % W) == 0;
            if (exp_fv) begin
                exp_fd_m = exp_data(1'b1);
                exp_fd_l = exp_data(1'b0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1);
        checks++;
        if (data_m !== 8'h00) begin
            errors++;
            $display("FAIL reset_msb: got %h expected 00", data_m);
        end
        checks++;
        if (data_l !== 8'h00) begin
            errors++;
            $display("FAIL reset_lsb: got %h expected 00", data_l);
        end
`ifdef S2P_FRAME_EN
        checks++;
        if (fv_m !== 1'b0 || fd_m !== 8'h00) begin
            errors++;
            $display("FAIL reset_frame: got fv=%b fd=%h expected fv=0 fd=00", fv_m, fd_m);
        end
`endif
    endtask

    task automatic test_word_shift();
        logic [9:0] pat;
        logic [W-1:0] want;
        pat = 10'b0011011101;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, pat[9-i]);
            checks++;
            if (data_m !== exp_data(1'b1)) begin
                errors++;
                $display("FAIL word_shift_msb[%0d]: got %h expected %h", i, data_m, exp_data(1'b1));
            end
            checks++;
            if (data_l !== exp_data(1'b0)) begin
                errors++;
                $display("FAIL word_shift_lsb[%0d]: got %h expected %h", i, data_l, exp_data(1'b0));
            end
            if (i >= 7) begin
                want = (i == 7) ? 8'h37 : (i == 8) ? 8'h6E : 8'hDD;
                checks++;
                if (data_m !== want) begin
                    errors++;
                    $display("FAIL word_value[%0d]: got %h expected %h", i, data_m, want);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < int'(W); i++) drive(1'b0, p == 0);
            checks++;
            if (data_m !== ((p == 0) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL saturation_msb[%0d]: got %h expected %h", p, data_m,
                         (p == 0) ? 8'hFF : 8'h00);
            end
            checks++;
            if (data_l !== ((p == 0) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL saturation_lsb[%0d]: got %h expected %h", p, data_l,
                         (p == 0) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [7:0] pat;
        pat = 8'hDD;
        for (int i = 0; i < 8; i++) drive(1'b0, pat[7-i]);
        checks++;
        if (data_m !== 8'hDD) begin
            errors++;
            $display("FAIL prio_preload: got %h expected dd", data_m);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (data_m !== 8'h00) begin
            errors++;
            $display("FAIL prio_reset: got %h expected 00", data_m);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (data_m !== 8'h01) begin
            errors++;
            $display("FAIL prio_first_bit: got %h expected 01", data_m);
        end
        checks++;
        if (data_l !== 8'h80) begin
            errors++;
            $display("FAIL prio_first_bit_lsb: got %h expected 80", data_l);
        end
    endtask

    task automatic test_direction();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0);
        checks++;
        if (data_l !== 8'h01) begin
            errors++;
            $display("FAIL direction_lsb: got %h expected 01", data_l);
        end
        checks++;
        if (data_m !== 8'h80) begin
            errors++;
            $display("FAIL direction_msb: got %h expected 80", data_m);
        end
    endtask

`ifdef S2P_FRAME_EN
    task automatic test_frame();
        logic [7:0] pat;
        pat = 8'h37;
        drive(1'b1, 1'b0);
        // first frame, then seven quiet bits and a second pulse
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, (i < 8) ? pat[7-i] : 1'($urandom_range(0, 1)));
            checks++;
            if (fv_m !== ((i % 8) == 7) || fv_l !== ((i % 8) == 7)) begin
                errors++;
                $display("FAIL frame_valid[%0d]: got %b/%b expected %b", i, fv_m, fv_l, (i % 8) == 7);
            end
            checks++;
            if (fd_m !== exp_fd_m || fd_l !== exp_fd_l) begin
                errors++;
                $display("FAIL frame_data[%0d]: got %h/%h expected %h/%h", i, fd_m, fd_l,
                         exp_fd_m, exp_fd_l);
            end
            if (i == 7) begin
                checks++;
                if (fd_m !== 8'h37) begin
                    errors++;
                    $display("FAIL frame_first: got %h expected 37", fd_m);
                end
            end
        end
        // reset after 4 bits restarts the count
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (fv_m !== (i == 7)) begin
                errors++;
                $display("FAIL frame_restart[%0d]: got %b expected %b", i, fv_m, i == 7);
            end
        end
        checks++;
        if (fd_m !== exp_data(1'b1)) begin
            errors++;
            $display("FAIL frame_restart_data: got %h expected %h", fd_m, exp_data(1'b1));
        end
    endtask
`endif

    task automatic test_random();
        bit r;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            drive(r, 1'($urandom_range(0, 1)));
            checks++;
            if (data_m !== exp_data(1'b1) || data_l !== exp_data(1'b0)) begin
                errors++;
                $display("FAIL random_data[%0d]: got %h/%h expected %h/%h", i, data_m, data_l,
                         exp_data(1'b1), exp_data(1'b0));
            end
`ifdef S2P_FRAME_EN
            checks++;
            if (fv_m !== exp_fv || fv_l !== exp_fv || fd_m !== exp_fd_m || fd_l !== exp_fd_l) begin
                errors++;
                $display("FAIL random_frame[%0d]: got %b %h/%b %h expected %b %h/%h", i,
                         fv_m, fd_m, fv_l, fd_l, exp_fv, exp_fd_m, exp_fd_l);
            end
`endif
        end
    endtask

    initial begin
        rst      = 1'b1;
        din      = 1'b0;
        nbits    = 0;
        exp_fv   = 1'b0;
        exp_fd_m = '0;
        exp_fd_l = '0;
        test_reset();
        test_word_shift();
        test_saturation();
        test_reset_priority();
        test_direction();
`ifdef S2P_FRAME_EN
        test_frame();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
